// File: rtl/mem_pkg.sv
// Shared defaults and state encoding for the mem_responder block and its delay pipe.
package mem_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_LATENCY    = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-length shift register carrying {valid, wr, data} from request acceptance to response.
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_wr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] wr_q, wr_d;
  logic [DATA_W-1:0]  data_q [LATENCY];
  logic [DATA_W-1:0]  data_d [LATENCY];

  always_comb begin
    valid_d[0] = in_valid;
    wr_d[0]    = in_wr;
    data_d[0]  = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      wr_d[i]    = wr_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Payload is cleared alongside valid so the outputs stay zero between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wr_q    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_wr    = wr_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: clears its storage after reset, then serves one
// read/write per cycle with a fixed-latency, in-order, zero-backpressure response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  mem_we_d;
  logic [DEPTH_LOG2-1:0] mem_idx_d;
  logic [DATA_W-1:0]     mem_wdata_d;

  logic                  accept;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  pipe_in_wr;
  logic [DATA_W-1:0]     pipe_in_data;
  logic                  unused_addr_bits;

  assign req_ready = (state_q == RUN);
  assign init_done = (state_q == RUN);
  assign accept    = req_valid & req_ready;
  assign req_idx   = req_addr[DEPTH_LOG2:1];

  // Byte-lane bit and aliased high bits do not select storage.
  assign unused_addr_bits = ^req_addr;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we_d    = 1'b0;
    mem_idx_d   = req_idx;
    mem_wdata_d = req_wdata;
    unique case (state_q)
      INIT: begin
        mem_we_d    = 1'b1;
        mem_idx_d   = clr_cnt_q;
        mem_wdata_d = '0;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_we_d = accept & req_wr;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_idx_d] <= mem_wdata_d;
    end
  end

  // Read data is taken before this cycle's write lands, so it enters the pipe's first stage.
  assign pipe_in_wr   = accept & req_wr;
  assign pipe_in_data = (accept && !req_wr) ? mem_q[req_idx] : '0;

  mem_delay_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_delay_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_wr     (pipe_in_wr),
    .in_data   (pipe_in_data),
    .out_valid (rsp_valid),
    .out_wr    (rsp_wr),
    .out_data  (rsp_rdata)
  );

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning word width.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the word count stored.
REQ-004 The block SHALL have parameter LATENCY, default 4, meaning accept-to-response delay in cycles (legal 1..8).
REQ-005 The block SHALL have ports with one clock; reset is synchronous and active-high:
  clk        in   1       clock, all state on rising edge
  rst        in   1       synchronous active-high reset
  req_valid  in   1       request present
  req_ready  out  1       block can accept a request this cycle
  req_wr     in   1       1 = write, 0 = read
  req_addr   in   ADDR_W  byte address; word index = req_addr[DEPTH_LOG2:1]; bit 0 ignored
  req_wdata  in   DATA_W  write data
  rsp_valid  out  1       response present, one cycle per accepted request
  rsp_wr     out  1       echo of req_wr for this response
  rsp_rdata  out  DATA_W  read data; 0 for write responses
  init_done  out  1       memory clear complete

Function
REQ-006 A request SHALL be accepted in any cycle where req_valid and req_ready are both 1.
REQ-007 FSM states SHALL be INIT and RUN; INIT->RUN after the clear counter writes the last word; RUN has no exit except rst.
REQ-008 In INIT the block SHALL write 0 to one word per cycle at index = clear counter, counter 0..2^DEPTH_LOG2-1, then leave INIT.
REQ-009 req_ready SHALL be 0 in INIT and 1 in RUN; init_done SHALL equal (state == RUN).
REQ-010 Requests presented while req_ready = 0 SHALL be ignored without side effects.
REQ-011 An accepted write SHALL update storage at the end of the accept cycle.
REQ-012 An accepted read SHALL sample storage at the end of the accept cycle; a read accepted in cycle N+1 SHALL return data written in cycle N.
REQ-013 The response for a request accepted in cycle N SHALL appear with rsp_valid = 1 in cycle N+LATENCY exactly.
REQ-014 One request per cycle SHALL be accepted back-to-back with no bubbles; responses SHALL return in acceptance order.
REQ-015 The response path SHALL have no backpressure; every accepted request yields exactly one response.
REQ-016 rsp_rdata and rsp_wr SHALL be 0 whenever rsp_valid = 0.
REQ-017 Address bits above DEPTH_LOG2 SHALL be ignored (aliasing wrap-around).

Reset
REQ-018 rst SHALL force state INIT, clear counter 0, all pipeline valid bits 0, rsp_valid/rsp_wr/rsp_rdata 0, req_ready 0, init_done 0 on the next edge.
REQ-019 rst asserted mid-operation SHALL drop every in-flight response; no rsp_valid SHALL appear until a request is accepted after the new INIT completes.
REQ-020 rst asserted during INIT SHALL restart the clear from index 0.

Structure
REQ-021 A shared package mem_pkg SHALL hold ADDR_W/DATA_W defaults, the default LATENCY, and the state enumeration (INIT, RUN).
REQ-022 The LATENCY-stage delay line for {valid, wr, data} SHALL be a sub-module mem_delay_pipe instantiated once, with storage and FSM in mem_responder.

Verification
REQ-023 Reset, then count cycles -> req_ready = 0 for exactly 1024 cycles, init_done = 1 from cycle 1024 onward (DEPTH_LOG2 = 10).
REQ-024 After init, read addr 0x0010 -> rsp_valid exactly 4 cycles later with rsp_rdata = 0x0000.
REQ-025 Write 0xBEEF to 0x0020 in cycle N, read 0x0020 in cycle N+1 -> write response at N+4 (rsp_wr = 1, rsp_rdata = 0), read response at N+5 with 0xBEEF.
REQ-026 Issue 8 back-to-back writes, then 8 back-to-back reads of addresses 0x0000..0x000E -> 16 consecutive responses, reads return written data in order.
REQ-027 Write 0x1234 to 0x0002, read 0x0802 -> returns 0x1234 (aliasing).
REQ-028 Assert rst for 1 cycle with 3 reads in flight -> no rsp_valid for those reads; after re-init, earlier-written data reads back 0x0000.
